// File: rtl/mesh_term_pkg.sv
// Shared header layout, stamping helper and counter widths for the mesh terminal ingress FIFO.
// Field offsets are counted down from the packet MSB.
package mesh_term_pkg;

  localparam int NXT_JUMP_W = 8;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 4;
  localparam int ROW_OFS    = NXT_JUMP_W;
  localparam int COL_OFS    = ROW_OFS + ROW_W;
  localparam int MODE_OFS   = COL_OFS + COL_W;
  localparam int HDR_W      = MODE_OFS + 1;
  localparam int DROP_CNT_W = 16;

  typedef logic [HDR_W-1:0] hdr_t;

  // Clears next-jump; row, column and mode pass through unchanged.
  function automatic hdr_t stamp_hdr(input hdr_t hdr);
    return hdr & hdr_t'({(HDR_W-NXT_JUMP_W){1'b1}});
  endfunction

endpackage

// File: rtl/mesh_term_ptr.sv
// Wrap-around circular-buffer pointer: advances by one on inc and wraps from DEPTH-1 to 0.
module mesh_term_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mesh_term_in_fifo.sv
// Terminal-side ingress FIFO for one mesh port: show-ahead head, next-jump stamped on write.
// Define MESH_TERM_DEST_CHECK_EN to drop pushes whose target row/column lies outside the mesh.
module mesh_term_in_fifo
  import mesh_term_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 8,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [pckg_sz-1:0]                data_in,
  output logic                              full,
  output logic                              pndng_i_in,
  output logic [pckg_sz-1:0]                data_out_i_in,
  input  logic                              popin,
  output logic [$clog2(fifo_depth+1)-1:0]   count,
  output logic [DROP_CNT_W-1:0]             drop_cnt
);

  localparam int PW = $clog2(fifo_depth);
  localparam int CW = $clog2(fifo_depth + 1);

  // Terminal IDs ROWS+1 / COLUMS+1 must still fit the 4-bit header fields.
  if (pckg_sz < 24 || fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
      ROWS + 1 > 15 || COLUMS + 1 > 15) begin : g_bad_param
    $error("mesh_term_in_fifo: unsupported parameter set");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [pckg_sz-1:0]    mem_q [fifo_depth];
  logic [pckg_sz-1:0]    mem_d [fifo_depth];
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  pndng_q, pndng_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  pop_ok, accepted, dest_ok;
  logic [pckg_sz-1:0]    wdata;

`ifdef MESH_TERM_DEST_CHECK_EN
  logic [ROW_W-1:0] tgt_row;
  logic [COL_W-1:0] tgt_col;
  assign tgt_row = data_in[pckg_sz-1-ROW_OFS -: ROW_W];
  assign tgt_col = data_in[pckg_sz-1-COL_OFS -: COL_W];
  assign dest_ok = (int'(tgt_row) <= ROWS + 1) && (int'(tgt_col) <= COLUMS + 1);
`else
  assign dest_ok = 1'b1;
`endif

  assign wdata = {stamp_hdr(data_in[pckg_sz-1 -: HDR_W]), data_in[pckg_sz-HDR_W-1:0]};

  always_comb begin
    pop_ok   = popin & pndng_q;
    // A pop in the same cycle frees the slot, so a full buffer can still take the push.
    accepted = push & (~full_q | pop_ok) & dest_ok;
    count_d  = count_q;
    case ({accepted, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(fifo_depth));
    pndng_d = (count_d != '0);
    drop_d  = drop_q;
    if (push && !accepted && drop_q != '1) drop_d = drop_q + 1'b1;
    mem_d = mem_q;
    if (accepted) mem_d[wr_ptr] = wdata;
  end

  mesh_term_ptr #(.DEPTH(fifo_depth)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc   (accepted),
    .ptr   (wr_ptr)
  );

  mesh_term_ptr #(.DEPTH(fifo_depth)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  // Storage is cleared on reset so the head output reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      pndng_q <= 1'b0;
      drop_q  <= '0;
      for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      pndng_q <= pndng_d;
      drop_q  <= drop_d;
      for (int i = 0; i < fifo_depth; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign full          = full_q;
  assign pndng_i_in    = pndng_q;
  assign count         = count_q;
  assign drop_cnt      = drop_q;
  assign data_out_i_in = mem_q[rd_ptr];

endmodule

// File: tb/tb_mesh_term_in_fifo.sv
// Scoreboard bench for mesh_term_in_fifo: a queue model predicts accepted packets and
// occupancy; a negedge monitor checks every popped head against the expected queue.
module tb_mesh_term_in_fifo;

  localparam int W = 40;
  localparam int D = 8;
  localparam int R = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         push = 1'b0;
  logic         popin = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         full, pndng_i_in;
  logic [W-1:0] data_out_i_in;
  logic [3:0]   count;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  mesh_term_in_fifo #(.pckg_sz(W), .fifo_depth(D), .ROWS(R), .COLUMS(C)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .data_in       (data_in),
    .full          (full),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .count         (count),
    .drop_cnt      (drop_cnt)
  );

  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  int           mcount = 0;
  int           mdrop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] stamp(input logic [W-1:0] d);
    logic [W-1:0] s;
    s = d;
    s[W-1 -: 8] = 8'h00;
    return s;
  endfunction

  function automatic bit dest_ok(input logic [W-1:0] d);
`ifdef MESH_TERM_DEST_CHECK_EN
    return (int'(d[W-9 -: 4]) <= R + 1) && (int'(d[W-13 -: 4]) <= C + 1);
`else
    return 1'b1;
`endif
  endfunction

  // Drive one cycle of stimulus, advance the model, then check the state after the edge.
  task automatic cycle(input bit p, input logic [W-1:0] d, input bit q);
    bit pop_ok, acc;
    push = p; data_in = d; popin = q;
    pop_ok = q && (mcount > 0);
    acc = p && (mcount < D || pop_ok) && dest_ok(d);
    if (acc) exp_q.push_back(stamp(d));
    if (p && !acc && mdrop < 65535) mdrop++;
    mcount = mcount + int'(acc) - int'(pop_ok);
    @(posedge clk); #1;
    chk("count", 64'(count), 64'(mcount));
    chk("full", 64'(full), 64'(mcount == D));
    chk("pndng", 64'(pndng_i_in), 64'(mcount != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
  endtask

  always @(negedge clk) begin
    if (reset && popin && pndng_i_in) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL head: got pndng_i_in=1 expected empty buffer");
      end else begin
        chk("head", 64'(data_out_i_in), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [63:0]  r;
    logic [W-1:0] d;
    int           pp;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pndng", 64'(pndng_i_in), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_data", 64'(data_out_i_in), 64'd0);

    cycle(1'b1, 40'hFF_1_2_00ABCD, 1'b0);
    chk("stamped_head", 64'(data_out_i_in), 64'h00_1_2_00ABCD);
    cycle(1'b0, '0, 1'b1);

    for (int i = 0; i < D; i++) cycle(1'b1, {8'hA0 + 8'(i), 4'd1, 4'd1, 24'(i * 4099 + 7)}, 1'b0);
    cycle(1'b1, {8'hEE, 4'd2, 4'd2, 24'hDEAD01}, 1'b0);
    cycle(1'b1, {8'hEF, 4'd3, 4'd3, 24'hBEEF02}, 1'b1);
    for (int i = 0; i < D; i++) cycle(1'b0, '0, 1'b1);

    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, {8'h11, 4'd0, 4'd5, 24'h000111}, 1'b0);
    cycle(1'b1, {8'h12, 4'd5, 4'd5, 24'h000222}, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    cycle(1'b1, {8'h33, 4'd7, 4'd3, 24'h111111}, 1'b0);
    cycle(1'b1, {8'h44, 4'd5, 4'd0, 24'h222222}, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Asynchronous reset with entries stored and a nonzero drop count.
    for (int i = 0; i < 3; i++) cycle(1'b1, {8'h50 + 8'(i), 4'd1, 4'd4, 24'(i + 100)}, 1'b0);
    push = 1'b0; popin = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_pndng", 64'(pndng_i_in), 64'd0);
    chk("async_rst_drop", 64'(drop_cnt), 64'd0);
    chk("async_rst_full", 64'(full), 64'd0);
    exp_q.delete(); mcount = 0; mdrop = 0;
    @(posedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0: pp = 80;
        1: pp = 50;
        default: pp = 20;
      endcase
      r = {$urandom, $urandom};
      d = r[W-1:0];
      if ($urandom_range(3) != 0) begin
        d[W-9 -: 4]  = 4'($urandom_range(5));
        d[W-13 -: 4] = 4'($urandom_range(5));
      end
      cycle(($urandom_range(99) < pp), d, ($urandom_range(99) < 100 - pp + 10));
    end

    for (int i = 0; i < D + 2; i++) cycle(1'b0, '0, 1'b1);
    push = 1'b0; popin = 1'b0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
